img_count_bank: RTL and testbench
=================================

IMG_COUNT_BANK -- requirements
Module: img_count_bank

Interface
REQ-001 Parameter NUM_CH, default 2, number of image-type channels (legal 1..16); ch0 = nav, ch1 = science.
REQ-002 Parameter CNT_W, default 16, per-channel counter width (legal 1..32).
REQ-003 Parameter SATURATE, default 1; 1 = counter holds at max, 0 = counter wraps to 0.
REQ-004 Parameter CLEAR_ON_FLUSH, default 0; 1 = live counters and overflow flags cleared at flush snapshot.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 img_added  input  NUM_CH  per-channel increment request, sampled every clk; bit i high = +1 to channel i.
REQ-008 clear_counts  input  1  synchronous clear of live counters and overflow flags.
REQ-009 start_flush  input  1  request to stream a snapshot; sampled every clk.
REQ-010 out_word  output  32  streamed data word.
REQ-011 out_valid  output  1  out_word valid.
REQ-012 out_ready  input  1  sink accepts word; transfer = out_valid & out_ready in same cycle.
REQ-013 out_last  output  1  high with the final word of a flush.
REQ-014 flush_busy  output  1  high while not in IDLE.
REQ-015 ovf_flags  output  NUM_CH  live sticky overflow flag per channel.

Function
REQ-016 Each channel SHALL keep a CNT_W-bit live counter, incremented by 1 in any cycle its img_added bit is high; all channels independent, simultaneous increments on several channels all counted.
REQ-017 At count 2^CNT_W-1 with increment: SATURATE=1 holds the value; SATURATE=0 wraps to 0; in both cases ovf_flags[i] SHALL set and remain set until cleared.
REQ-018 clear_counts SHALL zero all live counters and ovf_flags next cycle; clear_counts wins over a same-cycle increment (result 0).
REQ-019 FSM states: IDLE, SEND; IDLE -> SEND when start_flush high in IDLE; SEND -> IDLE on transfer with out_last high.
REQ-020 On the IDLE->SEND edge the block SHALL copy all live counters and ovf_flags into a snapshot buffer; snapshot includes increments of earlier cycles only, not the same-cycle increment.
REQ-021 With CLEAR_ON_FLUSH=1, the live counter SHALL load its same-cycle img_added bit (0 or 1) and ovf_flags SHALL clear at snapshot; clear_counts in that cycle forces 0.
REQ-022 out_valid SHALL assert the cycle after start_flush is accepted (latency 1) and stay high until the last word transfers.
REQ-023 Word order: words 0..NUM_CH-1 = snapshot count of ch0..chNUM_CH-1, zero-extended to 32 bits; word NUM_CH = snapshot ovf_flags zero-extended, with out_last=1; total NUM_CH+1 words.
REQ-024 out_word and out_last SHALL hold stable while out_valid & !out_ready; word index advances by one per transfer only.
REQ-025 Back-to-back transfers (out_ready held high) SHALL yield one word per cycle.
REQ-026 start_flush while in SEND SHALL be ignored (not queued); a new flush is accepted only in IDLE, earliest the cycle after the last transfer.
REQ-027 Live counting, clear_counts and ovf_flags SHALL operate normally during SEND and SHALL NOT alter the snapshot being streamed.
REQ-028 flush_busy SHALL equal (state == SEND).

Reset
REQ-029 rst_n low SHALL immediately force: all live counters 0, snapshot 0, ovf_flags 0, state IDLE, word index 0, out_valid 0, out_last 0, out_word 0, flush_busy 0.
REQ-030 Reset mid-SEND SHALL abort the stream with no further words; after release the block accepts a new start_flush normally.

Verification
REQ-031 Defaults; 3 pulses ch0, 5 pulses ch1 (one cycle both high), start_flush, out_ready=1 -> words 0x00000003, 0x00000005, 0x00000000 (last); out_valid high exactly 3 cycles starting 1 cycle after flush.
REQ-032 CNT_W=4, SATURATE=1, 17 pulses ch0, flush -> word0 0x0000000F, status word 0x00000001; SATURATE=0 same stimulus -> word0 0x00000001, status 0x00000001.
REQ-033 Flush with out_ready low 4 cycles then high; inject 2 ch1 pulses and a second start_flush during SEND -> words held stable, snapshot unchanged, second flush ignored, flush_busy low after last word.
REQ-034 CLEAR_ON_FLUSH=1; ch0 at 7, start_flush in same cycle as ch0 pulse -> streamed 0x00000007, live ch0 = 1 afterwards; next flush streams 0x00000001.
REQ-035 clear_counts and ch1 pulse same cycle with ch1 at 9 -> ch1 = 0; rst_n low during word 1 of a flush -> out_valid 0 immediately, counters 0, next flush streams all-zero words.

Source files
------------

// File: rtl/img_count_bank.sv
// Per-channel image counters with sticky overflow flags and a snapshot streamer.
// Latency: first word valid 1 cycle after start_flush is accepted; one word per transfer.
// Backpressure: out_word/out_last hold while out_valid & !out_ready; start_flush ignored while busy.
module img_count_bank #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned SATURATE       = 1,
    parameter int unsigned CLEAR_ON_FLUSH = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] img_added,
    input  logic              clear_counts,
    input  logic              start_flush,
    output logic [31:0]       out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              flush_busy,
    output logic [NUM_CH-1:0] ovf_flags
);

    localparam int unsigned      IDX_W    = $clog2(NUM_CH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  snap_q [NUM_CH];
    logic [CNT_W-1:0]  snap_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] snap_ovf_q, snap_ovf_d;

    logic flush_acc;
    logic xfer;

    assign flush_acc = (state_q == ST_IDLE) && start_flush;
    assign xfer      = out_valid && out_ready;

    // Live counters: clear beats flush-clear, which beats a normal increment.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clear_counts) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if ((CLEAR_ON_FLUSH != 0) && flush_acc) begin
                cnt_d[i] = CNT_W'(img_added[i]);
                ovf_d[i] = 1'b0;
            end else if (img_added[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = (SATURATE != 0) ? CNT_MAX : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Snapshot captures the registered counts, so same-cycle increments are excluded.
    always_comb begin
        snap_d     = snap_q;
        snap_ovf_d = snap_ovf_q;
        if (flush_acc) begin
            snap_d     = cnt_q;
            snap_ovf_d = ovf_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_flush) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        out_word = '0;
        if (state_q == ST_SEND) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    out_word[CNT_W-1:0] = snap_q[i];
                end
            end
            if (idx_q == LAST_IDX) begin
                out_word[NUM_CH-1:0] = snap_ovf_q;
            end
        end
    end

    assign out_valid  = (state_q == ST_SEND);
    assign out_last   = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    assign flush_busy = (state_q == ST_SEND);
    assign ovf_flags  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '{default: '0};
            snap_q     <= '{default: '0};
            ovf_q      <= '0;
            snap_ovf_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            ovf_q      <= ovf_d;
            snap_ovf_q <= snap_ovf_d;
        end
    end

endmodule

// File: tb/tb_img_count_bank.sv
// Directed bench for img_count_bank: four instances cover defaults, 4-bit saturate/wrap and clear-on-flush.
module tb_img_count_bank;

    logic        clk;
    logic        rst_n;
    logic [1:0]  add [4];
    logic        clr [4];
    logic        sf  [4];
    logic        rdy [4];
    logic [31:0] ow  [4];
    logic        ov  [4];
    logic        ol  [4];
    logic        fb  [4];
    logic [1:0]  of  [4];

    int nvec = 0;
    int nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    img_count_bank u_def (
        .clk(clk), .rst_n(rst_n), .img_added(add[0]), .clear_counts(clr[0]),
        .start_flush(sf[0]), .out_word(ow[0]), .out_valid(ov[0]), .out_ready(rdy[0]),
        .out_last(ol[0]), .flush_busy(fb[0]), .ovf_flags(of[0])
    );

    img_count_bank #(.CNT_W(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .img_added(add[1]), .clear_counts(clr[1]),
        .start_flush(sf[1]), .out_word(ow[1]), .out_valid(ov[1]), .out_ready(rdy[1]),
        .out_last(ol[1]), .flush_busy(fb[1]), .ovf_flags(of[1])
    );

    img_count_bank #(.CNT_W(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .img_added(add[2]), .clear_counts(clr[2]),
        .start_flush(sf[2]), .out_word(ow[2]), .out_valid(ov[2]), .out_ready(rdy[2]),
        .out_last(ol[2]), .flush_busy(fb[2]), .ovf_flags(of[2])
    );

    img_count_bank #(.CLEAR_ON_FLUSH(1)) u_cof (
        .clk(clk), .rst_n(rst_n), .img_added(add[3]), .clear_counts(clr[3]),
        .start_flush(sf[3]), .out_word(ow[3]), .out_valid(ov[3]), .out_ready(rdy[3]),
        .out_last(ol[3]), .flush_busy(fb[3]), .ovf_flags(of[3])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k, input logic [1:0] v, input int n);
        for (int p = 0; p < n; p++) begin
            add[k] = v;
            tick();
        end
        add[k] = 2'b00;
    endtask

    task automatic start(input int k);
        sf[k] = 1'b1;
        tick();
        sf[k] = 1'b0;
        add[k] = 2'b00;
    endtask

    // Expects the instance already in SEND showing word 0 with out_ready high.
    task automatic drain(input int k, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2);
        logic [31:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("i%0d_w%0d_valid", k, w), 32'(ov[k]), 32'd1);
            chk($sformatf("i%0d_w%0d_busy", k, w), 32'(fb[k]), 32'd1);
            chk($sformatf("i%0d_w%0d_word", k, w), ow[k], e[w]);
            chk($sformatf("i%0d_w%0d_last", k, w), 32'(ol[k]), (w == 2) ? 32'd1 : 32'd0);
            tick();
        end
        chk($sformatf("i%0d_end_valid", k), 32'(ov[k]), 32'd0);
        chk($sformatf("i%0d_end_busy", k), 32'(fb[k]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            add[k] = 2'b00; clr[k] = 1'b0; sf[k] = 1'b0; rdy[k] = 1'b0;
        end
        #12;
        chk("rst_word", ow[0], 32'd0);
        chk("rst_valid", 32'(ov[0]), 32'd0);
        chk("rst_last", 32'(ol[0]), 32'd0);
        chk("rst_busy", 32'(fb[0]), 32'd0);
        chk("rst_ovf", 32'(of[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ch0 = 3, ch1 = 5 with one cycle both high
        pulse(0, 2'b01, 2);
        pulse(0, 2'b11, 1);
        pulse(0, 2'b10, 4);
        rdy[0] = 1'b1;
        chk("pre_flush_valid", 32'(ov[0]), 32'd0);
        start(0);
        drain(0, 32'h3, 32'h5, 32'h0);

        // stalled flush: ch1 pulses and second start_flush during SEND
        rdy[0] = 1'b0;
        start(0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d_valid", c), 32'(ov[0]), 32'd1);
            chk($sformatf("stall%0d_word", c), ow[0], 32'h3);
            chk($sformatf("stall%0d_last", c), 32'(ol[0]), 32'd0);
            add[0] = (c == 0 || c == 2) ? 2'b10 : 2'b00;
            sf[0]  = (c == 1);
            tick();
        end
        add[0] = 2'b00;
        sf[0]  = 1'b0;
        rdy[0] = 1'b1;
        drain(0, 32'h3, 32'h5, 32'h0);
        tick();
        chk("second_flush_ignored", 32'(fb[0]), 32'd0);
        start(0);
        drain(0, 32'h3, 32'h7, 32'h0);

        // clear_counts beats same-cycle ch1 increment with ch1 at 9
        pulse(0, 2'b10, 2);
        clr[0] = 1'b1;
        add[0] = 2'b10;
        tick();
        clr[0] = 1'b0;
        add[0] = 2'b00;
        pulse(0, 2'b01, 1);
        start(0);
        drain(0, 32'h1, 32'h0, 32'h0);

        // 4-bit counters, 17 pulses: saturate vs wrap
        for (int p = 0; p < 17; p++) begin
            add[1] = 2'b01; add[2] = 2'b01;
            tick();
        end
        add[1] = 2'b00; add[2] = 2'b00;
        chk("sat_ovf_live", 32'(of[1]), 32'h1);
        chk("wrap_ovf_live", 32'(of[2]), 32'h1);
        rdy[1] = 1'b1; rdy[2] = 1'b1;
        start(1);
        drain(1, 32'hF, 32'h0, 32'h1);
        start(2);
        drain(2, 32'h1, 32'h0, 32'h1);

        // clear-on-flush: ch0 at 7, pulse coincident with start_flush
        pulse(3, 2'b01, 7);
        rdy[3] = 1'b1;
        add[3] = 2'b01;
        start(3);
        drain(3, 32'h7, 32'h0, 32'h0);
        start(3);
        drain(3, 32'h1, 32'h0, 32'h0);

        // reset during word 1 of a flush
        pulse(0, 2'b11, 2);
        start(0);
        chk("pre_rst_w0", ow[0], 32'h3);
        tick();
        chk("pre_rst_w1", ow[0], 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov[0]), 32'd0);
        chk("mid_rst_word", ow[0], 32'd0);
        chk("mid_rst_last", 32'(ol[0]), 32'd0);
        chk("mid_rst_busy", 32'(fb[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(ov[0]), 32'd0);
        start(0);
        drain(0, 32'h0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
